// File: rtl/jk_pkg.sv
// Shared JK flip-flop command encoding and the excitation lookup used to
// steer a JK cell from its present state to a requested next state.
package jk_pkg;

   typedef logic [1:0] jk_cmd_t;

   localparam jk_cmd_t HOLD   = 2'b00;
   localparam jk_cmd_t RESET  = 2'b01;
   localparam jk_cmd_t SET    = 2'b10;
   localparam jk_cmd_t TOGGLE = 2'b11;

   // {J, K} for a q -> next transition; TOGGLE is never returned.
   function automatic jk_cmd_t jk_excite(input logic q, input logic next);
      jk_cmd_t cmd;
      cmd = HOLD;
      if (!q && next)
         cmd = SET;
      else if (q && !next)
         cmd = RESET;
      return cmd;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset to 0.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         case (jk_cmd_t'({j, k}))
            SET:     q <= 1'b1;
            RESET:   q <= 1'b0;
            TOGGLE:  q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter stored in a row of JK cells, with parallel
// load, combinational terminal count and registered carry/borrow pulses.
module jk_updown_counter
   import jk_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             carry,
   output logic             borrow
);

   if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_param
      $error("jk_updown_counter: WIDTH must be 1..16 and MODULUS 2..2**WIDTH");
   end

   localparam int unsigned      AW      = WIDTH + 1;
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [AW-1:0]    MAX_EXT = AW'(MODULUS - 1);

   logic [AW-1:0]    cnt_ext;
   logic [AW-1:0]    ld_ext;
   logic [WIDTH-1:0] next_cnt;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;
   logic             at_max;
   logic             at_zero;
   logic             carry_q;
   logic             borrow_q;

   assign at_max  = (count == MAX_CNT);
   assign at_zero = (count == '0);
   assign tc      = (up & at_max) | (~up & at_zero);
   assign carry   = carry_q;
   assign borrow  = borrow_q;

   // Next-count selection: reset, saturating load, wrapping step, hold.
   always_comb begin
      cnt_ext  = AW'(count);
      ld_ext   = AW'(load_val);
      next_cnt = count;
      if (rst) begin
         next_cnt = '0;
      end else if (load) begin
         next_cnt = (ld_ext > MAX_EXT) ? MAX_CNT : load_val;
      end else if (en && up) begin
         next_cnt = at_max ? '0 : WIDTH'(cnt_ext + AW'(1));
      end else if (en) begin
         next_cnt = at_zero ? MAX_CNT : WIDTH'(cnt_ext - AW'(1));
      end
   end

   // Per-bit excitation; only HOLD/SET/RESET ever reach the cells.
   always_comb begin
      j_vec = '0;
      k_vec = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         {j_vec[i], k_vec[i]} = jk_excite(count[i], next_cnt[i]);
      end
   end

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (j_vec[i]),
         .k   (k_vec[i]),
         .q   (count[i])
      );
   end

   // Wrap pulses line up with the wrapped count; load and reset suppress them.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         carry_q  <= ~load & en &  up & at_max;
         borrow_q <= ~load & en & ~up & at_zero;
      end
   end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed and randomized checks of jk_updown_counter (WIDTH=4, MODULUS=10).
module tb_jk_updown_counter;

   localparam int unsigned WIDTH   = 4;
   localparam int unsigned MODULUS = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             carry;
   logic             borrow;

   int n_cmp  = 0;
   int n_fail = 0;

   jk_updown_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .carry    (carry),
      .borrow   (borrow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_cnt;
      int m;
      logic mc, mb;
      int lv;
      int up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      int dn_seq [4]  = '{1, 0, 9, 8};

      rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
      #2;
      step();
      step();
      check("rst_count", 32'(count), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);
      up = 1'b0;
      #1;
      check("rst_tc_down", 32'(tc), 32'd1);
      up = 1'b1;
      #1;
      check("rst_tc_up", 32'(tc), 32'd0);

      // Up-wrap: 1..9, 0, 1, 2
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_cnt = up_seq[i];
         check("up_count", 32'(count), 32'(exp_cnt));
         check("up_carry", 32'(carry), (exp_cnt == 0) ? 32'd1 : 32'd0);
         check("up_tc", 32'(tc), (exp_cnt == 9) ? 32'd1 : 32'd0);
      end

      // Down-wrap from a loaded 2
      load = 1'b1; load_val = 4'd2; en = 1'b0;
      step();
      check("load2", 32'(count), 32'd2);
      load = 1'b0; en = 1'b1; up = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("dn_count", 32'(count), 32'(dn_seq[i]));
         check("dn_borrow", 32'(borrow), (i == 2) ? 32'd1 : 32'd0);
         check("dn_tc", 32'(tc), (dn_seq[i] == 0) ? 32'd1 : 32'd0);
         check("dn_carry", 32'(carry), 32'd0);
      end

      // Load priority over en at the terminal count
      up = 1'b1;
      step();
      check("to9_count", 32'(count), 32'd9);
      check("to9_carry", 32'(carry), 32'd0);
      load = 1'b1; load_val = 4'd5;
      step();
      check("ldpri_count", 32'(count), 32'd5);
      check("ldpri_carry", 32'(carry), 32'd0);
      load_val = 4'd13;
      step();
      check("ldsat13_count", 32'(count), 32'd9);
      load_val = 4'd15;
      step();
      check("ldsat15_count", 32'(count), 32'd9);
      check("ldsat_carry", 32'(carry), 32'd0);
      load_val = 4'd9;
      step();
      check("ld9_count", 32'(count), 32'd9);

      // Reset on the wrapping edge
      load = 1'b0; rst = 1'b1;
      step();
      check("rstwrap_count", 32'(count), 32'd0);
      check("rstwrap_carry", 32'(carry), 32'd0);
      rst = 1'b0;
      step();
      check("after_rst_count", 32'(count), 32'd1);
      check("after_rst_carry", 32'(carry), 32'd0);

      // Random run against a reference model; J=K=1 must never appear
      m = 1;
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 39) == 0);
         load     = ($urandom_range(0, 7) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up       = ($urandom_range(0, 2) != 0);
         lv       = int'($urandom_range(0, 15));
         load_val = 4'(lv);
         #1;
         check("no_toggle", 32'(dut.j_vec & dut.k_vec), 32'd0);
         mc = 1'b0;
         mb = 1'b0;
         if (rst) begin
            m = 0;
         end else if (load) begin
            m = (lv > 9) ? 9 : lv;
         end else if (en && up) begin
            mc = (m == 9);
            m  = (m == 9) ? 0 : m + 1;
         end else if (en) begin
            mb = (m == 0);
            m  = (m == 0) ? 9 : m - 1;
         end
         step();
         check("rnd_range", (32'(count) < 32'(MODULUS)) ? 32'd1 : 32'd0, 32'd1);
         check("rnd_count", 32'(count), 32'(m));
         check("rnd_carry", 32'(carry), 32'(mc));
         check("rnd_borrow", 32'(borrow), 32'(mb));
         check("rnd_tc", 32'(tc), ((up && m == 9) || (!up && m == 0)) ? 32'd1 : 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/jk_updown_counter.md
# jk_updown_counter

Synchronous modulo-N up/down counter built from a row of JK flip-flop cells. Each cycle the block derives a J/K excitation pair for every bit from the requested next count and drives one JK cell per bit, so it is the stage that feeds the JK storage elements. It provides parallel load, a terminal-count output for cascading, and registered one-cycle carry/borrow pulses. Typical use is a BCD digit (WIDTH=4, MODULUS=10) or a cascaded multi-digit timer.

## Interface
- WIDTH, 4: counter width in bits; legal range 1..16.
- MODULUS, 10: count range 0..MODULUS-1; legal range 2..2**WIDTH. An out-of-range value is an elaboration error.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high; sampled on the rising edge of clk.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load request; has priority over en.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (JK cell Q outputs).
- tc  out  1  combinational terminal count: (up & count==MODULUS-1) | (~up & count==0).
- carry  out  1  registered pulse; 1 for the single cycle after an up-wrap.
- borrow  out  1  registered pulse; 1 for the single cycle after a down-wrap.

One clock; reset is synchronous and active-high.

## Operation
- Next-count selection, in priority order:
  - rst: next=0.
  - load: next=min(load_val, MODULUS-1). Values at or above MODULUS saturate to MODULUS-1.
  - en & up: next=(count==MODULUS-1) ? 0 : count+1.
  - en & ~up: next=(count==0) ? MODULUS-1 : count-1.
  - Otherwise: next=count.
- Excitation per bit i: J[i] = ~count[i] & next[i]; K[i] = count[i] & ~next[i].
  - Result: HOLD (00) where the bit is unchanged, SET (10) for 0->1, RESET (01) for 1->0.
  - TOGGLE (11) is never issued. The excitation logic must never produce 11, and verification asserts this.
- Arithmetic is done in WIDTH+1 bits. Comparisons use MODULUS-1 zero-extended to the count width.
- carry/borrow registers:
  - carry_q <= ~rst & ~load & en & up & (count==MODULUS-1).
  - borrow_q <= ~rst & ~load & en & ~up & (count==0).
- Load and en asserted together: load wins, and no carry or borrow is produced.
- A direction change takes effect on the same edge it is sampled. There is no pipeline.

## Timing
- Reset values: count=0, carry=0, borrow=0. tc follows count/up combinationally, so with up=0 it reads 1 during reset.
- Latency: count reflects a load or step one edge after the request is sampled.
- A wrap edge updates count to the wrapped value. carry (or borrow) is 1 for exactly that following cycle, coincident with the wrapped value.
- tc is valid in the same cycle as count and up, with no register. A downstream digit uses en_next = en & tc.
- Reset mid-count forces count=0 on that edge and clears a pending carry/borrow. The pulse from a wrap sampled on that same edge is suppressed.
- Continuous en with up=1 and MODULUS=M produces a carry period of exactly M cycles.

## Structure
- Shared package jk_pkg:
  - JK command constants HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11.
  - A 2-bit jk_cmd_t typedef.
  - Excitation-lookup function jk_excite(q, next) returning jk_cmd_t.
- Sub-module jk_cell: single-bit JK flip-flop, synchronous active-high reset to 0, output q.
  - Instantiated WIDTH times in a generate loop.
  - All next-state and excitation logic stays in jk_updown_counter.

## Test plan
- Reset: hold rst for 2 cycles with en=1, up=1 -> count=0, carry=0, borrow=0; with up=0, tc=1.
- Up-wrap, WIDTH=4, MODULUS=10: from 0, en=1, up=1 for 12 cycles -> count 1..9, 0, 1, 2. carry=1 only in the cycle count=0. tc=1 only while count=9.
- Down-wrap: load 2, then en=1, up=0 for 4 cycles -> count 1, 0, 9, 8. borrow=1 only in the cycle count first reads 9.
- Load priority and saturation:
  - load=1, en=1, load_val=5 at count=9 -> count=5, no carry.
  - load_val=13 -> count=9.
- Reset mid-wrap: count=9, en=1, up=1, rst=1 on the same edge -> count=0, carry stays 0.
- Excitation assertion: for every cycle of a random en/up/load run, no bit receives J=K=1, and count stays in 0..MODULUS-1.
